// File: rtl/cme_ip_eth_mac_v3_pkg.sv
// Shared constants, FSM state type and helpers for the Ethernet MAC v3 TX
// frame reader (read side of the 2 x 384 x 32 ping-pong TX DPRAM).
package cme_ip_eth_mac_v3_pkg;

    localparam int BANK_WORDS = 384;
    localparam int MAX_LEN    = 4 * BANK_WORDS;
    localparam int LEN_W      = 11;
    localparam int AW         = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FILL,
        SEND,
        RELEASE
    } state_t;

    // Number of 32-bit words holding a frame of len bytes (partial last word rounds up).
    function automatic logic [LEN_W-1:0] words_for(input logic [LEN_W-1:0] len);
        return (len + LEN_W'(3)) >> 2;
    endfunction

endpackage

// File: rtl/cme_ip_tx_frame_reader_v3_if.sv
// Byte stream from the frame reader toward the MAC TX engine (valid/ready).
interface cme_ip_tx_frame_reader_v3_if;

    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_sop_o;
    logic       tx_eop_o;
    logic       tx_err_o;
    logic       tx_ready_i;

    modport master (
        output tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, tx_err_o,
        input  tx_ready_i
    );

    modport slave (
        input  tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, tx_err_o,
        output tx_ready_i
    );

endinterface

// File: rtl/cme_ip_tx_word_prefetch_v3.sv
// Two-deep word holding stage: the word being serialised (cur) plus one
// prefetched word (pf), and the byte-lane mux that picks the outgoing byte.
module cme_ip_tx_word_prefetch_v3
    import cme_ip_eth_mac_v3_pkg::*;
(
    input  logic        clkr,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] qr_i,
    input  logic        adv_i,
    input  logic [1:0]  lane_i,
    output logic        cur_vld_o,
    output logic        pf_vld_o,
    output logic [7:0]  byte_o
);

    logic [31:0] cur_q, cur_d, pf_q, pf_d;
    logic        cur_vld_q, cur_vld_d, pf_vld_q, pf_vld_d;

    // Shift pf into cur when cur is used up, then land returning RAM data in the first free slot.
    always_comb begin
        cur_d     = cur_q;
        cur_vld_d = cur_vld_q;
        pf_d      = pf_q;
        pf_vld_d  = pf_vld_q;
        if (adv_i) begin
            cur_d     = pf_q;
            cur_vld_d = pf_vld_q;
            pf_vld_d  = 1'b0;
        end
        if (load_i) begin
            if (!cur_vld_d) begin
                cur_d     = qr_i;
                cur_vld_d = 1'b1;
            end else begin
                pf_d     = qr_i;
                pf_vld_d = 1'b1;
            end
        end
        if (clr_i) begin
            cur_vld_d = 1'b0;
            pf_vld_d  = 1'b0;
        end
    end

    // Occupancy flags are the only state that needs a defined reset value.
    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            cur_vld_q <= 1'b0;
            pf_vld_q  <= 1'b0;
        end else begin
            cur_vld_q <= cur_vld_d;
            pf_vld_q  <= pf_vld_d;
        end
    end

    // Word data registers; contents are meaningless while the matching flag is clear.
    always_ff @(posedge clkr) begin
        cur_q <= cur_d;
        pf_q  <= pf_d;
    end

    // LSB-byte-first lane selection.
    always_comb begin
        case (lane_i)
            2'd0:    byte_o = cur_q[7:0];
            2'd1:    byte_o = cur_q[15:8];
            2'd2:    byte_o = cur_q[23:16];
            default: byte_o = cur_q[31:24];
        endcase
    end

    assign cur_vld_o = cur_vld_q;
    assign pf_vld_o  = pf_vld_q;

endmodule

// File: rtl/cme_ip_tx_frame_reader_v3.sv
// TX frame reader: waits for a ready DPRAM bank, reads its words with one
// word of prefetch, streams the bytes to the MAC and releases the bank.
module cme_ip_tx_frame_reader_v3
    import cme_ip_eth_mac_v3_pkg::*;
(
    input  logic                       clkr,
    input  logic                       rst,
    input  logic [1:0]                 buf_ready_i,
    input  logic [LEN_W-1:0]           buf_len0_i,
    input  logic [LEN_W-1:0]           buf_len1_i,
    input  logic                       abort_i,
    output logic [AW-1:0]              ar,
    output logic                       cer,
    output logic                       rd_ram_sel,
    output logic                       mti_rdy_o,
    input  logic [31:0]                qr,
    cme_ip_tx_frame_reader_v3_if.master tx,
    output logic [1:0]                 buf_done_o,
    output logic                       len_err_o
);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic [1:0]       armed_q, armed_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] rd_addr_q, rd_addr_d;
    logic             rd_pend_q;
    logic             abort_q, abort_d;

    logic [LEN_W-1:0] len_in, nwords;
    logic             cer_c, valid_c, sop_c, eop_c, err_now, adv, clr;
    logic [1:0]       done_c;
    logic             len_err_c;
    logic             cur_vld, pf_vld;
    logic [7:0]       lane_byte;

    assign len_in = sel_q ? buf_len1_i : buf_len0_i;
    assign nwords = words_for(len_q);

    // Next-state and output decode; a bank is only served after its ready has been seen low (edge-armed).
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        armed_d    = armed_q | ~buf_ready_i;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        rd_addr_d  = rd_addr_q;
        abort_d    = 1'b0;
        cer_c      = 1'b0;
        valid_c    = 1'b0;
        sop_c      = 1'b0;
        eop_c      = 1'b0;
        err_now    = 1'b0;
        adv        = 1'b0;
        clr        = 1'b0;
        done_c     = 2'b00;
        len_err_c  = 1'b0;
        case (state_q)
            IDLE: begin
                rd_addr_d  = '0;
                byte_cnt_d = '0;
                if (buf_ready_i[sel_q] && armed_q[sel_q]) begin
                    armed_d[sel_q] = 1'b0;
                    state_d        = START;
                end
            end
            START: begin
                clr     = 1'b1;
                abort_d = abort_i;
                len_d   = len_in;
                if (len_in == '0 || len_in > LEN_W'(MAX_LEN)) begin
                    len_err_c = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    cer_c   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                abort_d = abort_q | abort_i;
                cer_c   = (nwords > LEN_W'(1));
                state_d = SEND;
            end
            SEND: begin
                err_now = abort_q | abort_i;
                abort_d = err_now;
                valid_c = cur_vld;
                sop_c   = cur_vld && (byte_cnt_q == '0);
                eop_c   = cur_vld && ((byte_cnt_q == len_q - LEN_W'(1)) || err_now);
                cer_c   = !pf_vld && !rd_pend_q && (rd_addr_q < nwords) && !err_now;
                if (cur_vld && tx.tx_ready_i) begin
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    adv        = (byte_cnt_q[1:0] == 2'd3);
                    if (eop_c) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                clr           = 1'b1;
                done_c[sel_q] = 1'b1;
                sel_d         = ~sel_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cer_c) begin
            rd_addr_d = rd_addr_q + LEN_W'(1);
        end
    end

    // Control state; reset abandons any frame in progress without releasing its bank.
    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            armed_q    <= 2'b00;
            len_q      <= '0;
            byte_cnt_q <= '0;
            rd_addr_q  <= '0;
            rd_pend_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            armed_q    <= armed_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_pend_q  <= cer_c;
            abort_q    <= abort_d;
        end
    end

    cme_ip_tx_word_prefetch_v3 u_prefetch (
        .clkr      (clkr),
        .rst       (rst),
        .clr_i     (clr),
        .load_i    (rd_pend_q),
        .qr_i      (qr),
        .adv_i     (adv),
        .lane_i    (byte_cnt_q[1:0]),
        .cur_vld_o (cur_vld),
        .pf_vld_o  (pf_vld),
        .byte_o    (lane_byte)
    );

    assign cer           = cer_c;
    assign mti_rdy_o     = cer_c;
    assign ar            = cer_c ? rd_addr_q[AW-1:0] : '0;
    assign rd_ram_sel    = sel_q;
    assign buf_done_o    = done_c;
    assign len_err_o     = len_err_c;
    assign tx.tx_valid_o = valid_c;
    assign tx.tx_data_o  = valid_c ? lane_byte : 8'h00;
    assign tx.tx_sop_o   = sop_c;
    assign tx.tx_eop_o   = eop_c;
    assign tx.tx_err_o   = valid_c && err_now;

endmodule

// File: tb/tb_cme_ip_tx_frame_reader_v3.sv
// Bench for the TX frame reader: DPRAM model, expected-byte queue built from
// bank contents and lengths, and a per-cycle monitor comparing the stream.
module tb_cme_ip_tx_frame_reader_v3;

    logic        clkr = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  buf_ready_i;
    logic [10:0] buf_len0_i, buf_len1_i;
    logic        abort_i;
    logic [8:0]  ar;
    logic        cer, rd_ram_sel, mti_rdy_o;
    logic [31:0] qr;
    logic [1:0]  buf_done_o;
    logic        len_err_o;

    cme_ip_tx_frame_reader_v3_if tx ();

    cme_ip_tx_frame_reader_v3 dut (
        .clkr        (clkr),
        .rst         (rst),
        .buf_ready_i (buf_ready_i),
        .buf_len0_i  (buf_len0_i),
        .buf_len1_i  (buf_len1_i),
        .abort_i     (abort_i),
        .ar          (ar),
        .cer         (cer),
        .rd_ram_sel  (rd_ram_sel),
        .mti_rdy_o   (mti_rdy_o),
        .qr          (qr),
        .tx          (tx),
        .buf_done_o  (buf_done_o),
        .len_err_o   (len_err_o)
    );

    always #5 clkr = ~clkr;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       err;
    } exp_t;

    logic [31:0] mem [0:767];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  blog [0:4095];
    int          n_total = 0;
    int          n_pass  = 0;
    int          done_cnt [2];
    int          lenerr_cnt = 0;
    int          acc_total  = 0;
    int          max_ar     = 0;
    int          sel_model  = 0;
    logic        prev_hold;
    logic [7:0]  prev_data;

    // Synchronous-read DPRAM: data appears the cycle after cer.
    always @(posedge clkr) begin
        if (cer) qr <= mem[(rd_ram_sel ? 384 : 0) + int'(ar)];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, expv, $time);
    endtask

    task automatic fill_bank(input int b, input int len);
        int nw;
        nw = (len + 3) / 4;
        if (nw > 384) nw = 384;
        for (int i = 0; i < nw; i++) mem[b * 384 + i] = $urandom;
    endtask

    task automatic push_frame(input int b, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.d   = 8'(mem[b * 384 + i / 4] >> (8 * (i % 4)));
            e.sop = (i == 0);
            e.eop = (i == len - 1);
            e.err = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int b, input int target, input int budget, input bit rnd);
        int n;
        n = 0;
        while (done_cnt[b] < target && n < budget) begin
            @(posedge clkr); #1;
            if (rnd) tx.tx_ready_i = 1'($urandom_range(0, 1));
            n++;
        end
        chk($sformatf("done_seen_bank%0d", b), 32'(done_cnt[b] >= target), 32'd1);
        buf_ready_i[b] = 1'b0;
        tx.tx_ready_i  = 1'b1;
    endtask

    task automatic wait_bytes(input int base, input int cnt, input int budget);
        int n;
        n = 0;
        while (acc_total - base < cnt && n < budget) begin
            @(posedge clkr); #1;
            n++;
        end
        chk("byte_count_reached", 32'(acc_total - base), 32'(cnt));
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    initial begin
        prev_hold   = 1'b0;
        prev_data   = 8'h00;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(negedge clkr);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                chk("mti_rdy_eq_cer", 32'(mti_rdy_o), 32'(cer));
                if (cer) begin
                    chk("ar_in_bank", 32'(int'(ar) < 384), 32'd1);
                    if (int'(ar) > max_ar) max_ar = int'(ar);
                end
                if (prev_hold) begin
                    chk("stall_valid_held", 32'(tx.tx_valid_o), 32'd1);
                    chk("stall_data_stable", 32'(tx.tx_data_o), 32'(prev_data));
                end
                if (tx.tx_valid_o) begin
                    chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (tx.tx_ready_i && exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("data", 32'(tx.tx_data_o), 32'(mon_e.d));
                        chk("sop", 32'(tx.tx_sop_o), 32'(mon_e.sop));
                        chk("eop", 32'(tx.tx_eop_o), 32'(mon_e.eop));
                        chk("err", 32'(tx.tx_err_o), 32'(mon_e.err));
                        blog[acc_total % 4096] = tx.tx_data_o;
                        acc_total++;
                    end
                end
                prev_hold = tx.tx_valid_o && !tx.tx_ready_i;
                prev_data = tx.tx_data_o;
                if (buf_done_o[0]) done_cnt[0]++;
                if (buf_done_o[1]) done_cnt[1]++;
                if (len_err_o) lenerr_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base, d0, d1, le, n, gaps, len;
        exp_t tmp;
        buf_ready_i   = 2'b00;
        buf_len0_i    = '0;
        buf_len1_i    = '0;
        abort_i       = 1'b0;
        tx.tx_ready_i = 1'b1;
        for (int i = 0; i < 768; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clkr);
        @(negedge clkr);
        chk("rst_valid", 32'(tx.tx_valid_o), 32'd0);
        chk("rst_cer", 32'(cer), 32'd0);
        chk("rst_sel", 32'(rd_ram_sel), 32'd0);
        chk("rst_done", 32'(buf_done_o), 32'd0);
        chk("rst_lenerr", 32'(len_err_o), 32'd0);
        @(posedge clkr); #1 rst = 1'b0;
        repeat (2) @(posedge clkr);
        #1;

        // T1: len=64 on bank 0, MAC always ready
        fill_bank(0, 64);
        mem[0] = 32'h44332211;
        buf_len0_i = 11'd64;
        push_frame(0, 64);
        base = acc_total; d0 = done_cnt[0]; d1 = done_cnt[1];
        buf_ready_i[0] = 1'b1;
        n = 0;
        do begin
            @(posedge clkr); #1;
            n++;
        end while (!tx.tx_valid_o && n < 20);
        chk("t1_first_byte_latency", 32'(n), 32'd3);
        gaps = 0; n = 0;
        while (acc_total - base < 64 && n < 200) begin
            if (!tx.tx_valid_o) gaps++;
            @(posedge clkr); #1;
            n++;
        end
        chk("t1_bubbles", 32'(gaps), 32'd0);
        wait_done(0, d0 + 1, 50, 1'b0);
        repeat (3) @(posedge clkr);
        #1;
        chk("t1_bytes", 32'(acc_total - base), 32'd64);
        chk("t1_byte0", 32'(blog[base % 4096]), 32'h11);
        chk("t1_byte1", 32'(blog[(base + 1) % 4096]), 32'h22);
        chk("t1_done0_once", 32'(done_cnt[0] - d0), 32'd1);
        chk("t1_done1_none", 32'(done_cnt[1] - d1), 32'd0);
        chk("t1_sel", 32'(rd_ram_sel), 32'd1);

        // T3: len=7 on bank 1, MAC ready toggling randomly
        mem[384] = 32'h03020100;
        mem[385] = 32'h07060504;
        buf_len1_i = 11'd7;
        push_frame(1, 7);
        base = acc_total; d1 = done_cnt[1];
        buf_ready_i[1] = 1'b1;
        wait_done(1, d1 + 1, 400, 1'b1);
        repeat (2) @(posedge clkr);
        #1;
        chk("t3_bytes", 32'(acc_total - base), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t3_byte%0d", i), 32'(blog[(base + i) % 4096]), 32'(i));
        chk("t3_sel", 32'(rd_ram_sel), 32'd0);

        // T2: both banks ready, len0=5, len1=1536
        mem[0] = 32'hDDCCBBAA;
        mem[1] = 32'h123456EE;
        fill_bank(1, 1536);
        buf_len0_i = 11'd5;
        buf_len1_i = 11'd1536;
        push_frame(0, 5);
        push_frame(1, 1536);
        base = acc_total; d0 = done_cnt[0]; d1 = done_cnt[1];
        max_ar = 0;
        buf_ready_i = 2'b11;
        wait_done(0, d0 + 1, 50, 1'b0);
        wait_done(1, d1 + 1, 2000, 1'b0);
        repeat (2) @(posedge clkr);
        #1;
        chk("t2_bytes", 32'(acc_total - base), 32'd1541);
        chk("t2_b0_byte0", 32'(blog[base % 4096]), 32'hAA);
        chk("t2_b0_byte4", 32'(blog[(base + 4) % 4096]), 32'hEE);
        chk("t2_b1_byte0", 32'(blog[(base + 5) % 4096]), 32'(mem[384][7:0]));
        chk("t2_max_ar", 32'(max_ar), 32'd383);
        chk("t2_sel", 32'(rd_ram_sel), 32'd0);
        chk("t2_done", 32'((done_cnt[0] - d0) + (done_cnt[1] - d1)), 32'd2);

        // T4: illegal lengths on both banks
        buf_len0_i = 11'd0;
        buf_len1_i = 11'd1537;
        base = acc_total; d0 = done_cnt[0]; d1 = done_cnt[1]; le = lenerr_cnt;
        buf_ready_i = 2'b11;
        wait_done(0, d0 + 1, 20, 1'b0);
        wait_done(1, d1 + 1, 20, 1'b0);
        repeat (2) @(posedge clkr);
        #1;
        chk("t4_lenerr", 32'(lenerr_cnt - le), 32'd2);
        chk("t4_no_bytes", 32'(acc_total - base), 32'd0);
        chk("t4_done0", 32'(done_cnt[0] - d0), 32'd1);
        chk("t4_done1", 32'(done_cnt[1] - d1), 32'd1);
        chk("t4_sel", 32'(rd_ram_sel), 32'd0);

        // T5: abort at byte 10 of a 100-byte frame
        fill_bank(0, 100);
        buf_len0_i = 11'd100;
        push_frame(0, 100);
        base = acc_total; d0 = done_cnt[0];
        buf_ready_i[0] = 1'b1;
        wait_bytes(base, 10, 100);
        abort_i = 1'b1;
        tmp = exp_q[0];
        tmp.eop = 1'b1;
        tmp.err = 1'b1;
        exp_q.delete();
        exp_q.push_back(tmp);
        @(posedge clkr); #1 abort_i = 1'b0;
        wait_done(0, d0 + 1, 50, 1'b0);
        repeat (4) @(posedge clkr);
        #1;
        chk("t5_bytes", 32'(acc_total - base), 32'd11);
        chk("t5_byte10", 32'(blog[(base + 10) % 4096]), 32'(mem[2][23:16]));
        chk("t5_done0", 32'(done_cnt[0] - d0), 32'd1);
        sel_model = 1;

        // Random frames alternating banks, MAC ready random
        for (int k = 0; k < 5; k++) begin
            if (k == 0) len = 1;
            else if (k == 1) len = 4;
            else if (k == 2) len = 5;
            else len = int'($urandom_range(1, 48));
            fill_bank(sel_model, len);
            if (sel_model == 0) buf_len0_i = 11'(len);
            else buf_len1_i = 11'(len);
            push_frame(sel_model, len);
            base = acc_total; d0 = done_cnt[sel_model];
            buf_ready_i[sel_model] = 1'b1;
            wait_done(sel_model, d0 + 1, 600, 1'b1);
            repeat (2) @(posedge clkr);
            #1;
            chk("rand_bytes", 32'(acc_total - base), 32'(len));
            sel_model = 1 - sel_model;
            chk("rand_sel", 32'(rd_ram_sel), 32'(sel_model));
        end

        // T6: reset at byte 20, bank must need a fresh ready edge afterwards
        fill_bank(0, 64);
        buf_len0_i = 11'd64;
        push_frame(0, 64);
        base = acc_total; d0 = done_cnt[0];
        buf_ready_i[0] = 1'b1;
        wait_bytes(base, 20, 100);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clkr);
        chk("t6_valid", 32'(tx.tx_valid_o), 32'd0);
        chk("t6_data", 32'(tx.tx_data_o), 32'd0);
        chk("t6_flags", 32'({tx.tx_sop_o, tx.tx_eop_o, tx.tx_err_o}), 32'd0);
        chk("t6_cer_ar", 32'({cer, ar}), 32'd0);
        chk("t6_done_lenerr", 32'({buf_done_o, len_err_o}), 32'd0);
        chk("t6_sel", 32'(rd_ram_sel), 32'd0);
        @(posedge clkr); #1;
        @(posedge clkr); #1 rst = 1'b0;
        repeat (20) @(posedge clkr);
        #1;
        chk("t6_not_reserved", 32'(acc_total - base), 32'd20);
        chk("t6_no_done", 32'(done_cnt[0] - d0), 32'd0);
        buf_ready_i[0] = 1'b0;
        @(posedge clkr); #1;
        fill_bank(0, 9);
        buf_len0_i = 11'd9;
        push_frame(0, 9);
        base = acc_total;
        buf_ready_i[0] = 1'b1;
        wait_done(0, d0 + 1, 100, 1'b0);
        repeat (2) @(posedge clkr);
        #1;
        chk("t6_rearmed_bytes", 32'(acc_total - base), 32'd9);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
